// File: rtl/alu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sequencer: the opcode encoding presented on
// the command interface and the sequencing FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_sequencer_if
// Command / result bus of the ALU sequencer.
//   master : upstream producer + downstream consumer (drives command, out_ready)
//   slave  : the sequencer (drives in_ready, results, status)
// Signals: in_valid/in_ready, opcode, a, b, carry_in      (command side)
//          out_valid/out_ready, result_low, result_high,
//          div_error, busy                                 (result side)
// -----------------------------------------------------------------------------
interface alu_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_low;
    logic [WIDTH-1:0] result_high;
    logic             div_error;
    logic             busy;

    modport master (
        output in_valid, opcode, a, b, carry_in, out_ready,
        input  in_ready, out_valid, result_low, result_high, div_error, busy
    );

    modport slave (
        input  in_valid, opcode, a, b, carry_in, out_ready,
        output in_ready, out_valid, result_low, result_high, div_error, busy
    );
endinterface

// File: rtl/alu_sequencer_div.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned restoring divider, one quotient bit per clock, WIDTH clocks after
// start_i. The divisor must be non-zero when start_i is asserted.
//   clk, rst      : clock, synchronous active-high reset (aborts a division)
//   start_i       : load dividend_i / divisor_i and begin
//   done_o        : high during the final step; quotient_o / remainder_o carry
//                   the final values in that same cycle
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH+1:0] trial_s;
    logic [WIDTH:0]   quo_shift_s;

    // One restoring step: shift next dividend bit into the remainder, trial-subtract.
    always_comb begin
        shifted_s   = {rem_q, quo_q[WIDTH-1]};
        trial_s     = {1'b0, shifted_s} - {2'b00, dvs_q};
        quo_shift_s = {quo_q, ~trial_s[WIDTH+1]};
        quo_d       = quo_shift_s[WIDTH-1:0];
        // A negative trial restores; otherwise the difference is below the divisor and fits WIDTH bits.
        if (trial_s[WIDTH+1]) begin
            rem_d = shifted_s[WIDTH-1:0];
        end else begin
            rem_d = trial_s[WIDTH-1:0];
        end
    end

    assign done_o      = (cnt_q == CW'(1));
    assign quotient_o  = quo_d;
    assign remainder_o = rem_d;

    // Divider state: load on start, step while the counter runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
            cnt_q <= CW'(WIDTH);
        end else if (cnt_q != '0) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
        end else begin
            rem_q <= rem_q;
            quo_q <= quo_q;
            cnt_q <= cnt_q;
        end
    end
endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle unsigned ALU: add/sub/mul finish one cycle after acceptance,
// non-zero divides take WIDTH cycles in seq_divider. Results are held until
// the consumer takes them.
//   clk, rst : clock, synchronous active-high reset (discards in-flight work)
//   bus      : alu_sequencer_if.slave command/result bus
// -----------------------------------------------------------------------------
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_sequencer_if.slave bus
);
    state_e state_q, state_d;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             cin_q;

    logic [WIDTH-1:0] res_low_q, res_low_d;
    logic [WIDTH-1:0] res_high_q, res_high_d;
    logic             div_err_q, div_err_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic             accept_s, div_start_s, div_done_s;
    logic [WIDTH-1:0] quo_s, rem_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [2*WIDTH-1:0] prod_s;

    // in_ready is deliberately combinational on rst so it is low during reset.
    assign bus.in_ready = (state_q == IDLE) && !rst;
    assign accept_s     = bus.in_valid && bus.in_ready;
    assign div_start_s  = accept_s && (bus.opcode == OP_DIV) && (bus.b != '0);

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start_s),
        .dividend_i  (bus.a),
        .divisor_i   (bus.b),
        .done_o      (div_done_s),
        .quotient_o  (quo_s),
        .remainder_o (rem_s)
    );

    assign sum_s  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    assign diff_s = a_q - b_q;
    assign prod_s = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = div_start_s ? DIV : EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC:    state_d = DONE;
            DIV: begin
                if (div_done_s) begin
                    state_d = DONE;
                end else begin
                    state_d = DIV;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: result registers load only on leaving EXEC or DIV, so they hold in DONE.
    always_comb begin
        res_low_d  = res_low_q;
        res_high_d = res_high_q;
        div_err_d  = div_err_q;
        case (state_q)
            EXEC: begin
                div_err_d = 1'b0;
                case (op_q)
                    OP_ADD: begin
                        res_low_d  = sum_s[WIDTH-1:0];
                        res_high_d = {{(WIDTH-1){1'b0}}, sum_s[WIDTH]};
                    end
                    OP_SUB: begin
                        res_low_d  = diff_s;
                        res_high_d = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
                    end
                    OP_MUL: begin
                        res_low_d  = prod_s[WIDTH-1:0];
                        res_high_d = prod_s[2*WIDTH-1:WIDTH];
                    end
                    // Only a zero-divisor divide reaches EXEC.
                    OP_DIV: begin
                        res_low_d  = '0;
                        res_high_d = a_q;
                        div_err_d  = 1'b1;
                    end
                    default: begin
                        res_low_d  = '0;
                        res_high_d = '0;
                    end
                endcase
            end
            DIV: begin
                if (div_done_s) begin
                    res_low_d  = quo_s;
                    res_high_d = rem_s;
                    div_err_d  = 1'b0;
                end else begin
                    res_low_d  = res_low_q;
                    res_high_d = res_high_q;
                    div_err_d  = div_err_q;
                end
            end
            default: begin
                res_low_d  = res_low_q;
                res_high_d = res_high_q;
                div_err_d  = div_err_q;
            end
        endcase
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // Command capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= 2'b00;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            res_low_q   <= '0;
            res_high_q  <= '0;
            div_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if (accept_s) begin
                op_q  <= bus.opcode;
                a_q   <= bus.a;
                b_q   <= bus.b;
                cin_q <= bus.carry_in;
            end
            res_low_q   <= res_low_d;
            res_high_q  <= res_high_d;
            div_err_q   <= div_err_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.result_low  = res_low_q;
    assign bus.result_high = res_high_q;
    assign bus.div_error   = div_err_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Directed bench for alu_sequencer (WIDTH=4). A latency/phase model derives the
// expected handshake and result values from the arithmetic definitions; a
// negedge process compares every cycle, and each directed vector also carries
// hand-computed results and latency.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;
    localparam int WIDTH = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Free-running clock.
    always #5 clk = ~clk;

    alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
    } res_t;

    // Result definitions straight from the arithmetic rules.
    function automatic res_t model_result(input int op, input int a, input int b, input int cin);
        res_t r;
        int   t;
        r = '0;
        case (op)
            0: begin t = a + b + cin; r.lo = t & MASK; r.hi = t >> WIDTH; end
            1: begin r.lo = (a - b) & MASK; r.hi = (a < b) ? 1 : 0; end
            2: begin t = a * b; r.lo = t & MASK; r.hi = t >> WIDTH; end
            default: begin
                if (b == 0) begin r.lo = 0; r.hi = a; r.err = 1'b1; end
                else        begin r.lo = a / b; r.hi = a % b; end
            end
        endcase
        return r;
    endfunction

    // Model: phase 0 idle, 1 computing, 2 result waiting for the consumer.
    int   m_phase = 0;
    int   m_wait  = 0;
    bit   m_clean = 1'b0;
    bit   m_init  = 1'b0;
    res_t m_exp   = '0;

    // Model update from the bench's own stimulus.
    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_clean <= 1'b1;
            m_init  <= 1'b1;
        end else if (m_init) begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    m_exp   <= model_result(int'(bus.opcode), int'(bus.a), int'(bus.b), int'(bus.carry_in));
                    m_wait  <= (bus.opcode == 2'd3 && bus.b != 4'd0) ? WIDTH : 1;
                    m_phase <= 1;
                end
                1: begin
                    m_wait <= m_wait - 1;
                    if (m_wait == 1) begin
                        m_phase <= 2;
                        m_clean <= 1'b0;
                    end
                end
                default: if (bus.out_ready) m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_init) begin
            check("in_ready",  int'(bus.in_ready),  int'(m_phase == 0 && !rst));
            check("busy",      int'(bus.busy),      int'(m_phase != 0));
            check("out_valid", int'(bus.out_valid), int'(m_phase == 2));
            if (m_phase == 2 || m_clean) begin
                check("result_low",  int'(bus.result_low),  m_clean ? 0 : int'(m_exp.lo));
                check("result_high", int'(bus.result_high), m_clean ? 0 : int'(m_exp.hi));
                check("div_error",   int'(bus.div_error),   m_clean ? 0 : int'(m_exp.err));
            end
        end
    end

    typedef struct {
        int op, a, b, cin;
        int lo, hi, err, lat;
        int hold, early;
    } vec_t;

    vec_t tbl [12];

    task automatic run_vec(input vec_t v);
        bit got;
        int lat;
        got = 1'b0;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.opcode    = 2'(v.op);
        bus.a         = WIDTH'(v.a);
        bus.b         = WIDTH'(v.b);
        bus.carry_in  = 1'(v.cin);
        bus.out_ready = 1'(v.early);
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk); #1;
        end
        if (!got) check("accept_timeout", 0, 1);
        // Scramble the command after acceptance; the captured copy must be used.
        bus.in_valid = 1'b0;
        bus.a        = ~bus.a;
        bus.b        = ~bus.b;
        bus.carry_in = ~bus.carry_in;
        bus.opcode   = ~bus.opcode;
        @(negedge clk);
        check("busy_after_accept", int'(bus.busy), 1);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            @(negedge clk);
        end
        check("latency",        lat,                      v.lat);
        check("lit_result_low", int'(bus.result_low),     v.lo);
        check("lit_result_high",int'(bus.result_high),    v.hi);
        check("lit_div_error",  int'(bus.div_error),      v.err);
        if (v.hold > 0) begin
            bus.in_valid = 1'b1;
            bus.opcode   = 2'd0;
            bus.a        = 4'd1;
            bus.b        = 4'd1;
            for (int h = 0; h < v.hold; h++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("hold_out_valid",  int'(bus.out_valid),  1);
                check("hold_in_ready",   int'(bus.in_ready),   0);
                check("hold_result_low", int'(bus.result_low), v.lo);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        check("released_out_valid", int'(bus.out_valid), 0);
        check("released_busy",      int'(bus.busy),      0);
    endtask

    task automatic reset_mid_div();
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.opcode   = 2'd3;
        bus.a        = 4'd13;
        bus.b        = 4'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("in_div_busy", int'(bus.busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst_drop", int'(bus.in_ready), 1);
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("no_result_after_rst", int'(seen), 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.opcode    = 2'd0;
        bus.a         = 4'd0;
        bus.b         = 4'd0;
        bus.carry_in  = 1'b0;
        bus.out_ready = 1'b0;

        //          op  a   b  cin  lo  hi err lat hold early
        tbl[0]  = '{0,  9,  8, 1,   2,  1, 0,  2,  0,  0};
        tbl[1]  = '{1,  3,  5, 0,  14,  1, 0,  2,  0,  0};
        tbl[2]  = '{2, 15, 15, 0,   1, 14, 0,  2,  0,  0};
        tbl[3]  = '{3, 13,  3, 0,   4,  1, 0,  5,  3,  0};
        tbl[4]  = '{3,  7,  0, 0,   0,  7, 1,  2,  0,  0};
        tbl[5]  = '{0, 15, 15, 1,  15,  1, 0,  2,  0,  1};
        tbl[6]  = '{1,  9,  3, 1,   6,  0, 0,  2,  0,  0};
        tbl[7]  = '{3, 15,  1, 0,  15,  0, 0,  5,  0,  0};
        tbl[8]  = '{3,  2,  7, 1,   0,  2, 0,  5,  0,  1};
        tbl[9]  = '{2,  0,  9, 0,   0,  0, 0,  2,  2,  0};
        tbl[10] = '{1,  5,  5, 0,   0,  0, 0,  2,  0,  0};
        tbl[11] = '{2,  7,  6, 1,  10,  2, 0,  2,  1,  0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready",   int'(bus.in_ready),   1);
        check("reset_result_low", int'(bus.result_low), 0);

        for (int i = 0; i < 12; i++) run_vec(tbl[i]);
        reset_mid_div();
        run_vec(tbl[0]);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset: clk and rst.
REQ-002 Parameter: WIDTH, default 4, operand width; all widths below scale with it, and verification SHALL cover WIDTH=4.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  command present.
REQ-006 in_ready  output  1  block accepts a command this cycle.
REQ-007 opcode  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-008 a, b  input  WIDTH each  operands; b is the divisor for div.
REQ-009 carry_in  input  1  add carry; ignored for other opcodes.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result_low  output  WIDTH  sum, difference, product[WIDTH-1:0], or quotient.
REQ-013 result_high  output  WIDTH  carry or borrow in bit 0 (other bits 0), product upper half, or remainder.
REQ-014 div_error  output  1  divide by zero; valid only while out_valid.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states: IDLE, EXEC, DIV, DONE.
REQ-017 Accept occurs when in_valid && in_ready; in_ready SHALL equal (state==IDLE && !rst).
REQ-018 On accept, opcode, a, b and carry_in SHALL be registered, so later input changes have no effect.
REQ-019 Accept with add, sub, or mul, or div with b==0: next state EXEC.
REQ-020 EXEC SHALL compute the result in one cycle and go to DONE, so out_valid rises at accept edge N+2.
REQ-021 Accept with div and b!=0: next state DIV.
REQ-022 DIV SHALL run an unsigned restoring divider, one quotient bit per cycle for exactly WIDTH cycles, then go to DONE, so out_valid rises at N+WIDTH+1.
REQ-023 add: {result_high[0], result_low} = a + b + carry_in, (WIDTH+1)-bit.
REQ-024 sub: result_low = (a - b) mod 2^WIDTH; result_high[0] = (a < b).
REQ-025 mul: {result_high, result_low} = a * b, full 2*WIDTH-bit unsigned product.
REQ-026 div, b!=0: quotient in result_low, remainder in result_high, div_error=0.
REQ-027 div, b==0: result_low=0, result_high=a, div_error=1.
REQ-028 DONE: out_valid=1, and results SHALL be held stable while out_ready=0.
REQ-029 DONE with out_ready=1: next state IDLE, out_valid=0 next cycle.
REQ-030 A new command cannot be accepted in the same cycle as a result handshake.
REQ-031 Maximum throughput SHALL be one command every 3 cycles for non-div opcodes.
REQ-032 in_valid while busy SHALL be ignored; the upstream holds the command until in_ready.
REQ-033 out_ready outside DONE SHALL have no effect.

Reset
REQ-034 With rst high at a clock edge, the next state SHALL be IDLE.
REQ-035 With rst high at a clock edge, all outputs SHALL be 0, including result_low, result_high, div_error, out_valid and busy.
REQ-036 rst SHALL take priority over any in-flight operation (EXEC, DIV or DONE), which is discarded with no result emitted.
REQ-037 in_ready SHALL first be 1 in the cycle after rst deasserts.

Structure
REQ-038 A shared package alu_pkg SHALL hold the opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV) and the FSM state enum.
REQ-039 The divider SHALL be a sub-module seq_divider with start/done handshake, b!=0 precondition and WIDTH-cycle latency.
REQ-040 The add, sub and mul datapath SHALL stay inline.

Verification
REQ-041 add a=9 b=8 carry_in=1 -> result_low=2, result_high=1 at N+2, div_error=0.
REQ-042 sub a=3 b=5 -> result_low=14, result_high=1; mul a=15 b=15 -> result_low=1, result_high=14.
REQ-043 div a=13 b=3 -> result_low=4, result_high=1, out_valid first high at N+5, busy high from N+1.
REQ-044 div a=7 b=0 -> div_error=1, result_low=0, result_high=7, at N+2.
REQ-045 Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid stays high -> outputs stable, in_ready=0, no second accept.
REQ-046 Reset mid-division: assert rst during DIV -> out_valid never rises; in_ready=1 the cycle after rst drops.
